// File: rtl/syn_fifo_pkg.sv
// rtl/syn_fifo_pkg.sv - shared constants and helpers for the parametrised FIFO
package syn_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Bits needed to index n distinct values; a minimum of 1 keeps port widths legal.
    function automatic int clog2(input int n);
        int v;
        int r;
        v = n - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module fifo_ram
    import syn_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_param.sv
// rtl/syn_fifo_param.sv - parametrised single-clock FIFO with thresholds, sticky flags and FWFT mode
module syn_fifo_param
    import syn_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = FWFT_OFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        wr_en_i,
    input  logic [DATA_W-1:0]           data_i,
    output logic                        full_o,
    output logic                        almost_full_o,
    output logic                        overflow_o,
    input  logic                        rd_en_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        valid_o,
    output logic                        empty_o,
    output logic                        almost_empty_o,
    output logic                        underflow_o,
    output logic [clog2(DEPTH+1)-1:0]   count_o
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = clog2(DEPTH + 1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              udf_q;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              empty;
    logic              full;
    logic              rd_acc;
    logic              wr_acc;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign rd_acc = rd_en_i && !empty;
    assign wr_acc = wr_en_i && (!full || rd_acc);

    // Explicit wrap so depths that are not a power of two cycle correctly.
    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !clear_i),
        .waddr (wr_ptr),
        .wdata (data_i),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else if (clear_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - 1'b1;
            end
            if (wr_en_i && !wr_acc) ovf_q <= 1'b1;
            if (rd_en_i && !rd_acc) udf_q <= 1'b1;
            vld_q <= rd_acc;
            if (rd_acc) dout_q <= ram_rdata;
        end
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= CNT_W'(AFULL_TH));
    assign almost_empty_o = (count_q <= CNT_W'(AEMPTY_TH));
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;
    assign count_o        = count_q;

    // FWFT masks the unreset storage while empty so data_o reads 0 after reset.
    assign data_o  = (FWFT == FWFT_ON) ? (empty ? '0 : ram_rdata) : dout_q;
    assign valid_o = (FWFT == FWFT_ON) ? !empty : vld_q;

endmodule

// File: tb/tb_syn_fifo_param.sv
// tb/tb_syn_fifo_param.sv - scoreboard bench for syn_fifo_param in three configurations
module tb_syn_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // DUT A: DEPTH=16, registered read
    logic       rst_a = 1'b0, a_clr = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_full, a_af, a_ovf, a_vld, a_emp, a_ae, a_udf;
    logic [4:0] a_cnt;

    syn_fifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst_a), .clear_i(a_clr), .wr_en_i(a_wr), .data_i(a_din),
        .full_o(a_full), .almost_full_o(a_af), .overflow_o(a_ovf), .rd_en_i(a_rd),
        .data_o(a_dout), .valid_o(a_vld), .empty_o(a_emp), .almost_empty_o(a_ae),
        .underflow_o(a_udf), .count_o(a_cnt)
    );

    // DUT B: DEPTH=5, registered read
    logic       rst_b = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_full, b_af, b_ovf, b_vld, b_emp, b_ae, b_udf;
    logic [2:0] b_cnt;

    syn_fifo_param #(.DATA_W(8), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(0)) dut_b (
        .clk(clk), .rst(rst_b), .clear_i(1'b0), .wr_en_i(b_wr), .data_i(b_din),
        .full_o(b_full), .almost_full_o(b_af), .overflow_o(b_ovf), .rd_en_i(b_rd),
        .data_o(b_dout), .valid_o(b_vld), .empty_o(b_emp), .almost_empty_o(b_ae),
        .underflow_o(b_udf), .count_o(b_cnt)
    );

    // DUT C: DEPTH=4, first-word-fall-through
    logic       rst_c = 1'b0, c_wr = 1'b0, c_rd = 1'b0;
    logic [7:0] c_din = '0, c_dout;
    logic       c_full, c_af, c_ovf, c_vld, c_emp, c_ae, c_udf;
    logic [2:0] c_cnt;

    syn_fifo_param #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) dut_c (
        .clk(clk), .rst(rst_c), .clear_i(1'b0), .wr_en_i(c_wr), .data_i(c_din),
        .full_o(c_full), .almost_full_o(c_af), .overflow_o(c_ovf), .rd_en_i(c_rd),
        .data_o(c_dout), .valid_o(c_vld), .empty_o(c_emp), .almost_empty_o(c_ae),
        .underflow_o(c_udf), .count_o(c_cnt)
    );

    logic [7:0] qa[$], qb[$], qc[$];

    always @(negedge clk) begin
        if (a_vld) begin
            if (qa.size() == 0) chk("a_unexpected_valid", {24'd0, a_dout}, 32'hDEAD);
            else chk("a_data", {24'd0, a_dout}, {24'd0, qa.pop_front()});
        end
        if (b_vld) begin
            if (qb.size() == 0) chk("b_unexpected_valid", {24'd0, b_dout}, 32'hDEAD);
            else chk("b_data", {24'd0, b_dout}, {24'd0, qb.pop_front()});
        end
        if (c_vld && c_rd) begin
            if (qc.size() == 0) chk("c_unexpected_pop", {24'd0, c_dout}, 32'hDEAD);
            else chk("c_data", {24'd0, c_dout}, {24'd0, qc.pop_front()});
        end
    end

    task automatic a_op(input logic w, input logic [7:0] d, input logic r);
        a_wr = w; a_din = d; a_rd = r;
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic b_op(input logic w, input logic [7:0] d, input logic r);
        b_wr = w; b_din = d; b_rd = r;
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic c_op(input logic w, input logic [7:0] d, input logic r);
        c_wr = w; c_din = d; c_rd = r;
        @(posedge clk); #1;
        c_wr = 1'b0; c_rd = 1'b0;
    endtask

    task automatic a_clear();
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        chk("rst_empty", a_emp, 1);
        chk("rst_aempty", a_ae, 1);
        chk("rst_full", a_full, 0);
        chk("rst_afull", a_af, 0);
        chk("rst_valid", a_vld, 0);
        chk("rst_data", a_dout, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_flags", {a_ovf, a_udf}, 0);
        chk("rst_c_valid", c_vld, 0);
        chk("rst_c_data", c_dout, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // 1: fill and drain
        for (int i = 0; i < 16; i++) begin
            a_op(1'b1, 8'(i), 1'b0);
            if (i == 12) chk("afull_at13", a_af, 0);
            if (i == 13) chk("afull_at14", a_af, 1);
            if (i == 14) chk("full_at15", a_full, 0);
        end
        chk("fill_full", a_full, 1);
        chk("fill_count", a_cnt, 16);
        for (int i = 0; i < 16; i++) begin
            qa.push_back(8'(i));
            a_op(1'b0, 8'h00, 1'b1);
            if (i == 12) chk("aempty_at3", a_ae, 0);
            if (i == 13) chk("aempty_at2", a_ae, 1);
        end
        chk("drain_empty", a_emp, 1);
        chk("drain_count", a_cnt, 0);

        // 2/3: overflow, push+pop when full, underflow
        for (int i = 0; i < 16; i++) a_op(1'b1, 8'(8'h10 + i), 1'b0);
        qa.push_back(8'h10);
        a_op(1'b1, 8'h20, 1'b1);
        chk("full_pushpop_count", a_cnt, 16);
        chk("full_pushpop_ovf", a_ovf, 0);
        a_op(1'b1, 8'h21, 1'b0);
        chk("ovf_count", a_cnt, 16);
        chk("ovf_set", a_ovf, 1);
        for (int i = 1; i < 16; i++) begin
            qa.push_back(8'(8'h10 + i));
            a_op(1'b0, 8'h00, 1'b1);
        end
        qa.push_back(8'h20);
        a_op(1'b0, 8'h00, 1'b1);
        a_op(1'b0, 8'h00, 1'b1);
        chk("udf_count", a_cnt, 0);
        chk("udf_set", a_udf, 1);
        chk("ovf_sticky", a_ovf, 1);
        repeat (3) a_op(1'b0, 8'h00, 1'b0);
        chk("flags_sticky", {a_ovf, a_udf}, 2'b11);
        a_clear();
        chk("clear_flags", {a_ovf, a_udf}, 0);
        a_op(1'b1, 8'h30, 1'b1);
        chk("empty_pushpop_count", a_cnt, 1);
        chk("empty_pushpop_udf", a_udf, 1);
        a_clear();
        chk("clear_count", a_cnt, 0);
        chk("clear_valid", a_vld, 0);
        for (int i = 0; i < 5; i++) a_op(1'b1, 8'(8'h40 + i), 1'b0);
        qa.push_back(8'h40);
        a_op(1'b1, 8'h45, 1'b1);
        chk("mid_pushpop_count", a_cnt, 5);
        for (int i = 1; i < 6; i++) begin
            qa.push_back(8'(8'h40 + i));
            a_op(1'b0, 8'h00, 1'b1);
        end

        // 6: async reset between edges
        for (int i = 0; i < 7; i++) a_op(1'b1, 8'(8'h50 + i), 1'b0);
        chk("pre_rst_count", a_cnt, 7);
        #2;
        rst_a = 1'b1;
        #1;
        chk("async_rst_count", a_cnt, 0);
        chk("async_rst_empty", a_emp, 1);
        chk("async_rst_aempty", a_ae, 1);
        #1;
        rst_a = 1'b0;
        @(posedge clk); #1;
        a_op(1'b1, 8'h33, 1'b0);
        qa.push_back(8'h33);
        a_op(1'b0, 8'h00, 1'b1);

        // 4: DEPTH=5 wrap
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                b_op(1'b1, 8'(8'hA0 + 5 * r + k), 1'b0);
                if (k == 3) chk("b_afull_at4", b_af, 1);
            end
            chk("b_full", b_full, 1);
            for (int k = 0; k < 5; k++) begin
                qb.push_back(8'(8'hA0 + 5 * r + k));
                b_op(1'b0, 8'h00, 1'b1);
            end
            chk("b_empty", b_emp, 1);
        end

        // 5: FWFT
        c_op(1'b1, 8'h5A, 1'b0);
        chk("c_valid_no_rd", c_vld, 1);
        chk("c_data_no_rd", c_dout, 8'h5A);
        qc.push_back(8'h5A);
        c_op(1'b0, 8'h00, 1'b1);
        chk("c_empty_after_pop", c_emp, 1);
        chk("c_valid_after_pop", c_vld, 0);
        c_op(1'b1, 8'h61, 1'b0);
        c_op(1'b1, 8'h62, 1'b0);
        qc.push_back(8'h61);
        c_op(1'b0, 8'h00, 1'b1);
        qc.push_back(8'h62);
        c_op(1'b0, 8'h00, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/syn_fifo_param.md
Name: syn_fifo_param

Overview:
Parametrised single-clock FIFO, the next generation of the 8x8 synchronous FIFO. It adds configurable width and depth (including non-power-of-two depths) and guarded push/pop. It also adds almost-full/almost-empty thresholds, sticky overflow/underflow flags, a synchronous flush, a live fill level, and a selectable first-word-fall-through (FWFT) read mode. It sits between any two same-clock producer/consumer blocks in the datapath.

Parameters:
DATA_W, 8, data word width (>=1)
DEPTH, 16, number of entries (>=2, any integer)
AFULL_TH, 14, almost_full_o asserts when count_o >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty_o asserts when count_o <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented on data_o without a read request
Derived localparams: ADDR_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
clear_i  in  1  synchronous flush
wr_en_i  in  1  push request
data_i  in  DATA_W  push data
full_o  out  1  count_o == DEPTH
almost_full_o  out  1  count_o >= AFULL_TH
overflow_o  out  1  sticky: push attempted while refused
rd_en_i  in  1  pop request
data_o  out  DATA_W  read data
valid_o  out  1  data_o qualifier
empty_o  out  1  count_o == 0
almost_empty_o  out  1  count_o <= AEMPTY_TH
underflow_o  out  1  sticky: pop attempted while empty
count_o  out  CNT_W  current fill level

Behaviour:
- Reset (rst high, async): wr_ptr, rd_ptr, count and flags go to 0. Outputs: data_o=0, valid_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, overflow_o=0, underflow_o=0. Memory contents are not reset.
- Status outputs are pure functions of registered count/flags; no input-to-status combinational path.
- rd_acc = rd_en_i && !empty_o.
- wr_acc = wr_en_i && (!full_o || rd_acc). When full, a simultaneous push and pop are both accepted and count is unchanged.
- When empty, a simultaneous push and pop: push accepted, pop refused, underflow_o set.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- Pointers increment on accept. They wrap from DEPTH-1 to 0 by explicit compare, not natural overflow, so non-power-of-two depths work.
- overflow_o is set when wr_en_i && !wr_acc. underflow_o is set when rd_en_i && !rd_acc. Both stay set until rst or clear_i.
- clear_i (highest priority after rst): pointers, count and both flags go to 0 at the next edge, and valid_o goes to 0. wr_en_i/rd_en_i in that cycle are ignored. data_o holds its value in FWFT=0.
- FWFT=0:
  - On rd_acc, data_o <= mem[rd_ptr] at the edge and valid_o=1 for exactly the following cycle.
  - Otherwise valid_o=0 and data_o holds its value.
  - A word pushed at edge N clears empty_o after edge N. The earliest pop is at edge N+1, with data visible after N+1.
- FWFT=1:
  - data_o = mem[rd_ptr] (combinational read of storage) and valid_o = !empty_o.
  - rd_en_i acknowledges the current head. A word pushed at edge N is visible on data_o after edge N.
- Throughput: one push and one pop per cycle sustained.

Decomposition:
- Shared package syn_fifo_pkg: clog2 function; FWFT_OFF=0 and FWFT_ON=1 constants.
- Sub-module fifo_ram: DEPTH x DATA_W storage with a synchronous write port and an asynchronous read port (parameters DATA_W, DEPTH).
- The top level holds pointers, count, flags, the mode mux and the output register.

Test Plan:
1. Reset/fill/drain, FWFT=0, DEPTH=16: push 0x00..0x0F. At count 14, almost_full_o=1; at 16, full_o=1. Pop 16 times: data_o returns 0x00..0x0F, each one cycle after its pop, valid_o pulsing. empty_o=1 at the end; almost_empty_o=1 from count 2.
2. Overflow/underflow: with the FIFO full, a 17th push leaves count=16 and sets overflow_o. Drain, then one pop on empty leaves count=0 and sets underflow_o. Both flags stay set until clear_i is pulsed, then read 0.
3. Simultaneous push and pop:
   - When full: both accepted, count stays 16, no overflow.
   - When empty: count becomes 1 and underflow_o=1.
   - At a mid level of 5: count stays 5 and order is preserved.
4. Non-power-of-two wrap, DEPTH=5: run 3 fill/drain cycles of 5 words (0xA0..0xAE). All 15 words are returned in order and pointers cross 4->0 three times.
5. FWFT=1: push 0x5A at edge N; after N, valid_o=1 and data_o=0x5A with no rd_en_i. Pop: empty_o=1, valid_o=0.
6. Async reset mid-operation: assert rst between edges at count 7. Outputs take reset values immediately, without waiting for a clock edge. After release, the next push of 0x33 is the next value read.
